// File: rtl/mips_pkg.sv
// Shared MIPS data-path definitions: access-size encodings, store-buffer entry
// layout and the byte-lane helpers used by the load/store unit.
package mips_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_ILL  = 2'd3
    } size_t;

    typedef struct packed {
        logic [29:0] addr;
        logic [3:0]  mask;
        logic [31:0] data;
    } sb_entry_t;

    // The illegal size code falls through to the word rules everywhere.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return off[0];
            default: return off != 2'b00;
        endcase
    endfunction

    function automatic logic [3:0] byte_mask(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_BYTE: return 4'b0001 << off;
            SZ_HALF: return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] mask_bits(input logic [3:0] mask);
        logic [31:0] bits;
        for (int k = 0; k < 4; k++) begin
            bits[8*k +: 8] = {8{mask[k]}};
        end
        return bits;
    endfunction

    function automatic logic [31:0] extend_load(input logic [31:0] word, input logic [1:0] size,
                                                input logic [1:0] off, input logic uns);
        logic [31:0] shifted;
        shifted = word >> {off, 3'b000};
        case (size)
            SZ_BYTE: return {{24{~uns & shifted[7]}}, shifted[7:0]};
            SZ_HALF: return {{16{~uns & shifted[15]}}, shifted[15:0]};
            default: return word;
        endcase
    endfunction

endpackage

// File: rtl/sb_fifo.sv
// In-order store buffer: circular FIFO of store entries, presented oldest-first,
// with a per-entry word-address compare against the current load address.
module sb_fifo
    import mips_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  sb_entry_t        push_entry,
    input  logic             pop,
    input  logic [29:0]      query_addr,
    output sb_entry_t        entries [DEPTH],
    output logic [DEPTH-1:0] hit_vec,
    output logic             full,
    output logic             empty
);
    localparam int PW = $clog2(DEPTH);

    sb_entry_t     slot_reg [DEPTH];
    logic [PW-1:0] rd_ptr_reg;
    logic [PW-1:0] wr_ptr_reg;
    logic [PW:0]   count_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                slot_reg[wr_ptr_reg] <= push_entry;
                wr_ptr_reg           <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= count_reg + (PW+1)'(push) - (PW+1)'(pop);
        end
    end

    // Index 0 is always the head, so callers see entries in age order.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_age
            logic [PW-1:0] idx;
            assign idx          = rd_ptr_reg + PW'(gi);
            assign entries[gi]  = slot_reg[idx];
            assign hit_vec[gi]  = ((PW+1)'(gi) < count_reg) && (slot_reg[idx].addr == query_addr);
        end
    endgenerate

    assign full  = count_reg == (PW+1)'(DEPTH);
    assign empty = count_reg == '0;

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit with a buffered, read-modify-write store path.
// Define LSU_FORWARD_EN to forward buffered store bytes to hitting loads instead of stalling.
module mem_lsu
    import mips_pkg::*;
#(
    parameter int SB_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic [31:0] load_data,
    output logic        misalign_err,
    input  logic        drain,
    output logic        sb_empty,
    output logic        mem_we,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);
    sb_entry_t             sb_entries [SB_DEPTH];
    sb_entry_t             head;
    sb_entry_t             push_entry;
    logic [SB_DEPTH-1:0]   hit_vec;
    logic                  sb_full;
    logic                  push;
    logic                  pop;
    logic [1:0]            off;
    logic                  misaligned;
    logic                  is_load;
    logic                  is_store;
    logic                  load_ok;
    logic                  load_accept;
    logic [31:0]           head_bits;
    logic [31:0]           load_word;

    assign off        = req_addr[1:0];
    assign misaligned = is_misaligned(req_size, off);
    assign is_load    = req_valid & ~req_we;
    assign is_store   = req_valid & req_we;

`ifdef LSU_FORWARD_EN
    assign load_ok = ~drain;
`else
    assign load_ok = ~drain & ~(|hit_vec);
`endif

    // Reset gating keeps the port quiet so buffered stores are discarded, not written.
    assign load_accept  = ~reset & is_load & load_ok;
    assign req_ready    = ~reset & (req_we | load_ok);
    assign misalign_err = (load_accept | (~reset & is_store)) & misaligned;

    assign head = sb_entries[0];
    assign pop  = ~reset & ~load_accept & ~sb_empty;
    assign push = ~reset & is_store & ~misaligned & (~sb_full | pop);

    assign push_entry = '{addr: req_addr[31:2],
                          mask: byte_mask(req_size, off),
                          data: req_wdata << {off, 3'b000}};

    sb_fifo #(
        .DEPTH(SB_DEPTH)
    ) u_sb_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .query_addr (req_addr[31:2]),
        .entries    (sb_entries),
        .hit_vec    (hit_vec),
        .full       (sb_full),
        .empty      (sb_empty)
    );

    assign head_bits = mask_bits(head.mask);
    assign mem_we    = pop;
    assign mem_a     = load_accept ? {req_addr[31:2], 2'b00} : {head.addr, 2'b00};
    assign mem_wd    = (mem_rd & ~head_bits) | (head.data & head_bits);

`ifdef LSU_FORWARD_EN
    // Oldest to youngest so the youngest store wins each byte lane.
    always_comb begin
        load_word = mem_rd;
        for (int i = 0; i < SB_DEPTH; i++) begin
            if (hit_vec[i]) begin
                load_word = (load_word & ~mask_bits(sb_entries[i].mask))
                          | (sb_entries[i].data & mask_bits(sb_entries[i].mask));
            end
        end
    end
`else
    assign load_word = mem_rd;
`endif

    assign load_data = (load_accept & ~misaligned)
                     ? extend_load(load_word, req_size, off, req_unsigned) : 32'h0;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: word-level memory model plus a store queue checked
// every cycle, and literal expectations for the extension, RMW, hazard and reset cases.
module tb_mem_lsu;
    localparam int SB_DEPTH = 4;
`ifdef LSU_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        preload;
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic [31:0] load_data;
    logic        misalign_err;
    logic        drain;
    logic        sb_empty;
    logic        mem_we;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    logic [31:0] tb_mem [64];
    logic [31:0] model_mem [64];

    typedef struct {
        logic [29:0] waddr;
        logic [3:0]  mask;
        logic [31:0] data;
    } pend_t;
    pend_t q[$];

    int          n_checks = 0;
    int          n_fail = 0;
    int          last_stalls;
    logic [31:0] last_ld;
    logic        last_mis;

    always #5 clk = ~clk;

    mem_lsu #(.SB_DEPTH(SB_DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_ready    (req_ready),
        .load_data    (load_data),
        .misalign_err (misalign_err),
        .drain        (drain),
        .sb_empty     (sb_empty),
        .mem_we       (mem_we),
        .mem_a        (mem_a),
        .mem_wd       (mem_wd),
        .mem_rd       (mem_rd)
    );

    function automatic logic [31:0] init_word(input int i);
        case (i)
            0:       return 32'h8070_FF01;
            1:       return 32'h1111_1111;
            8:       return 32'hAAAA_AAAA;
            default: return (32'(i) * 32'h0101_0101) ^ 32'h5A00_0000;
        endcase
    endfunction

    assign mem_rd = tb_mem[mem_a[7:2]];

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 64; i++) tb_mem[i] <= init_word(i);
        end else if (mem_we) begin
            tb_mem[mem_a[7:2]] <= mem_wd;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] m, input logic [31:0] d);
        logic [31:0] r;
        r = old;
        for (int k = 0; k < 4; k++) if (m[k]) r[8*k +: 8] = d[8*k +: 8];
        return r;
    endfunction

    function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] sz,
                                            input int off, input bit uns);
        logic [31:0] sh;
        logic [31:0] v;
        sh = word >> (8 * off);
        if (sz == 2'd0) begin
            v = sh & 32'hFF;
            if (!uns && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            v = sh & 32'hFFFF;
            if (!uns && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end else begin
            v = word;
        end
        return v;
    endfunction

    // Per-cycle model: expected outputs from current inputs, then the state after the next edge.
    task automatic model_cycle();
        bit          ld, st, mis, hit, exp_ready, acc_ld, acc, do_drain;
        int          off;
        logic [31:0] word, exp_ld, exp_wd;
        logic [3:0]  m;
        pend_t       e;
        if (reset) begin
            check("rst_mem_we", 32'(mem_we), 32'h0);
            check("rst_load_data", load_data, 32'h0);
            check("rst_misalign", 32'(misalign_err), 32'h0);
            q.delete();
            return;
        end
        check("sb_empty", 32'(sb_empty), 32'(q.size() == 0));
        ld  = req_valid && !req_we;
        st  = req_valid && req_we;
        off = int'(req_addr[1:0]);
        mis = (req_size == 2'd1 && off % 2 == 1) || (req_size >= 2'd2 && off != 0);
        hit = 0;
        foreach (q[i]) if (q[i].waddr == req_addr[31:2]) hit = 1;
        exp_ready = st || (!drain && (FWD || !hit));
        if (req_valid) check("req_ready", 32'(req_ready), 32'(exp_ready));
        acc_ld = ld && exp_ready;
        acc    = req_valid && exp_ready;
        check("misalign_err", 32'(misalign_err), 32'(acc && mis));
        exp_ld = 32'h0;
        if (acc_ld && !mis) begin
            word = model_mem[req_addr[7:2]];
            if (FWD) foreach (q[i]) if (q[i].waddr == req_addr[31:2]) word = merge(word, q[i].mask, q[i].data);
            exp_ld = extract(word, req_size, off, req_unsigned);
        end
        check("load_data", load_data, exp_ld);
        do_drain = !acc_ld && q.size() > 0;
        check("mem_we", 32'(mem_we), 32'(do_drain));
        if (acc_ld) check("mem_a_load", mem_a, {req_addr[31:2], 2'b00});
        if (do_drain) begin
            exp_wd = merge(model_mem[q[0].waddr[5:0]], q[0].mask, q[0].data);
            check("mem_a_drain", mem_a, {q[0].waddr, 2'b00});
            check("mem_wd", mem_wd, exp_wd);
            model_mem[q[0].waddr[5:0]] = exp_wd;
            void'(q.pop_front());
        end
        if (st && !mis) begin
            if (req_size == 2'd0)      m = 4'b0001 << off;
            else if (req_size == 2'd1) m = 4'b0011 << off;
            else                       m = 4'b1111;
            e.waddr = req_addr[31:2];
            e.mask  = m;
            e.data  = req_wdata << (8 * off);
            q.push_back(e);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) model_mem[i] = init_word(i);
        forever begin
            @(negedge clk);
            model_cycle();
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_op(input bit we, input logic [1:0] sz, input bit uns,
                         input logic [31:0] a, input logic [31:0] wd);
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = wd;
        last_stalls = 0;
        forever begin
            @(negedge clk);
            if (req_ready) break;
            last_stalls++;
            if (last_stalls > 20) begin
                n_checks++;
                n_fail++;
                $display("FAIL op_timeout: req_ready stayed 0 for addr %h", a);
                break;
            end
        end
        last_ld  = load_data;
        last_mis = misalign_err;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        $display("op we=%0d size=%0d uns=%0d addr=%h wdata=%h load_data=%h stalls=%0d mis=%0d",
                 we, sz, uns, a, wd, last_ld, last_stalls, last_mis);
    endtask

    initial begin
        reset = 1'b1; preload = 1'b1; drain = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0;
        @(posedge clk);
        #1 preload = 1'b0;
        @(negedge clk);
        check("reset_sb_empty", 32'(sb_empty), 32'h1);
        check("reset_mem_we", 32'(mem_we), 32'h0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Sign and zero extension over word 0 = 8070_FF01
        do_op(0, 2'd0, 0, 32'h3, 0); check("lb_3", last_ld, 32'hFFFF_FF80);
        do_op(0, 2'd0, 1, 32'h3, 0); check("lbu_3", last_ld, 32'h0000_0080);
        do_op(0, 2'd1, 0, 32'h2, 0); check("lh_2", last_ld, 32'hFFFF_8070);
        do_op(0, 2'd1, 1, 32'h2, 0); check("lhu_2", last_ld, 32'h0000_8070);
        do_op(0, 2'd2, 0, 32'h0, 0); check("lw_0", last_ld, 32'h8070_FF01);
        do_op(0, 2'd0, 0, 32'h1, 0); check("lb_1", last_ld, 32'hFFFF_FFFF);

        // Sub-word RMW
        do_op(1, 2'd0, 0, 32'h5, 32'h0000_00AB);
        idle(3);
        check("sb_rmw", tb_mem[1], 32'h1111_AB11);

        // Load hazard on a just-buffered word
        do_op(1, 2'd2, 0, 32'h10, 32'hDEAD_BEEF);
        do_op(0, 2'd2, 0, 32'h10, 0);
        check("hazard_stalls", 32'(last_stalls), FWD ? 32'h0 : 32'h1);
        check("hazard_data", last_ld, 32'hDEAD_BEEF);
        idle(2);

        // Overlapping sub-word stores then a word load
        do_op(1, 2'd1, 0, 32'h22, 32'h0000_1234);
        do_op(1, 2'd0, 0, 32'h23, 32'h0000_0056);
        do_op(0, 2'd2, 0, 32'h20, 0);
        check("fwd_stalls", 32'(last_stalls), FWD ? 32'h0 : 32'h1);
        check("fwd_data", last_ld, 32'h5634_AAAA);
        idle(3);
        check("fwd_mem", tb_mem[8], 32'h5634_AAAA);

        // Stores interleaved with loads, then a fifth store
        for (int k = 0; k < 4; k++) begin
            do_op(1, 2'd2, 0, 32'h40 + 32'(4 * k), 32'hC0DE_0000 + 32'(k));
            do_op(0, 2'd2, 0, 32'h0, 0);
        end
        do_op(1, 2'd2, 0, 32'h50, 32'hC0DE_0004);
        check("fifth_store_ready", 32'(last_stalls), 32'h0);
        idle(4);
        for (int k = 0; k < 5; k++) check("fill_word", tb_mem[16 + k], 32'hC0DE_0000 + 32'(k));

        // Misalignment
        do_op(0, 2'd2, 0, 32'h6, 0);
        check("mis_lw_err", 32'(last_mis), 32'h1);
        check("mis_lw_data", last_ld, 32'h0);
        do_op(1, 2'd1, 0, 32'h1, 32'h0000_FFFF);
        check("mis_sh_err", 32'(last_mis), 32'h1);
        idle(2);
        check("mis_sh_dropped", tb_mem[0], 32'h8070_FF01);
        check("mis_lw_mem", tb_mem[1], 32'h1111_AB11);

        // drain holds loads but not stores
        drain = 1'b1;
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h0;
        @(negedge clk); check("drain_stall_0", 32'(req_ready), 32'h0);
        @(negedge clk); check("drain_stall_1", 32'(req_ready), 32'h0);
        @(posedge clk); #1 req_valid = 1'b0;
        $display("op drain-held load addr=%h ready=%0d", req_addr, req_ready);
        do_op(1, 2'd2, 0, 32'h28, 32'h0BAD_F00D);
        check("drain_store_ready", 32'(last_stalls), 32'h0);
        idle(2);
        drain = 1'b0;
        check("drain_store_mem", tb_mem[10], 32'h0BAD_F00D);

        // Reset with a store still buffered
        do_op(1, 2'd2, 0, 32'h60, 32'h1234_5678);
        reset = 1'b1;
        @(negedge clk); check("pre_reset_pending", 32'(sb_empty), 32'h0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk); check("post_reset_empty", 32'(sb_empty), 32'h1);
        idle(3);
        check("reset_discard", tb_mem[24], init_word(24));

        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
